// File: rtl/cnn_acc_requant_21s_14s.sv
// Accumulates a stream of signed products into one dot product per vector. Each finished
// sum is requantized (round half up, then saturate) into an OUT_W result on a valid/ready port.
module cnn_acc_requant_21s_14s #(
  parameter int IN_W  = 21,
  parameter int ACC_W = 32,
  parameter int OUT_W = 14,
  parameter int SHIFT = 8,
  parameter int CNT_W = 10
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(2**(OUT_W-1)));

  logic [1:0]              r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_out_sat;
  logic [CNT_W-1:0]        r_out_count;

  logic                    w_in_fire;
  logic                    w_out_fire;
  logic signed [ACC_W-1:0] w_beat;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W:0]   w_r;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_hi;
  logic                    w_lo;

  assign out_valid  = (r_state == S_OUT);
  assign in_ready   = ap_rst_n && (!out_valid || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // acc is already zero in IDLE/OUT, so one adder serves every state
  assign w_beat    = ACC_W'($signed(in_data));
  assign w_sum     = r_acc + w_beat;
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) << (SHIFT - 1);
      logic signed [ACC_W:0] w_rnd;
      // one guard bit keeps the rounding add from wrapping
      assign w_rnd = {w_sum[ACC_W-1], w_sum} + RND;
      assign w_r   = w_rnd >>> SHIFT;
    end else begin : g_noround
      assign w_r = {w_sum[ACC_W-1], w_sum};
    end
  endgenerate

  assign w_hi = (w_r > MAXV);
  assign w_lo = (w_r < MINV);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_count <= '0;
    end else if (w_in_fire) begin
      if (in_last) begin
        r_state     <= S_OUT;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_out_data  <= w_hi ? MAXV[OUT_W-1:0] : w_lo ? MINV[OUT_W-1:0] : w_r[OUT_W-1:0];
        r_out_sat   <= w_hi || w_lo;
        r_out_count <= w_cnt_inc;
      end else begin
        r_state <= S_ACC;
        r_acc   <= w_sum;
        r_cnt   <= w_cnt_inc;
      end
    end else if (w_out_fire) begin
      r_state <= S_IDLE;
    end
  end

  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_cnn_acc_requant_21s_14s.sv
// Directed bench for cnn_acc_requant_21s_14s: rounding, saturation, backpressure,
// back-to-back vectors, counter saturation and mid-vector reset.
module tb_cnn_acc_requant_21s_14s;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [13:0] out_data;
  logic        out_sat;
  logic [9:0]  out_count;

  int n_chk = 0;
  int n_fail = 0;

  cnn_acc_requant_21s_14s dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_count(out_count)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // drive one beat, let it be taken on the next edge, sample 1 ns later
  task automatic beat(input int d, input logic last);
    in_valid = 1'b1;
    in_data  = 21'(d);
    in_last  = last;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int d, input logic s, input int c);
    check({tag, ".valid"}, longint'(out_valid), 1);
    check({tag, ".data"},  longint'($signed(out_data)), d);
    check({tag, ".sat"},   longint'(out_sat), longint'(s));
    check({tag, ".count"}, longint'(out_count), c);
  endtask

  int bb_d [8] = '{256, 256, 1024, -256, -512, -512, 100, 28};
  int bb_e [4] = '{2, 3, -4, 1};

  initial begin
    #2;
    check("rst.valid", out_valid, 0);
    check("rst.ready", in_ready, 0);
    check("rst.data", out_data, 0);
    check("rst.count", out_count, 0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("idle.ready", in_ready, 1);
    check("idle.valid", out_valid, 0);

    // 640/256 = 2.5 -> 3
    beat(256, 0); beat(512, 0); beat(-128, 1);
    chk_out("v3", 3, 0, 3);
    // -1.5 -> -1, transfers the previous result in the same edge
    beat(-384, 1);
    chk_out("v1neg", -1, 0, 1);
    beat(1048575, 0); beat(1048575, 0); beat(1048575, 1);
    chk_out("satp", 8191, 1, 3);
    beat(-1048576, 0); beat(-1048576, 0); beat(-1048576, 1);
    chk_out("satn", -8192, 1, 3);
    @(posedge ap_clk); #1;
    check("drain.valid", out_valid, 0);

    // backpressure: A={256} held, B's first beat waits at the input
    out_ready = 1'b0;
    beat(256, 1);
    in_valid = 1'b1; in_data = 21'(512); in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp.ready", in_ready, 0);
      chk_out("bp.A", 1, 0, 1);
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b1; #1;
    check("bp.ready_up", in_ready, 1);
    @(posedge ap_clk); #1;
    check("bp.A_gone", out_valid, 0);
    beat(512, 1);
    chk_out("bp.B", 4, 0, 2);

    // back-to-back, last every second beat, valid held high
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 21'(bb_d[i]);
      in_last  = (i % 2 == 1);
      @(posedge ap_clk); #1;
      if (i % 2 == 1) chk_out($sformatf("bb%0d", i / 2), bb_e[i / 2], 0, 2);
      else check($sformatf("bb_gap%0d", i / 2), out_valid, 0);
    end
    in_valid = 1'b0; in_last = 1'b0;

    // beat counter saturates at 1023
    for (int i = 0; i < 1029; i++) beat(0, 0);
    beat(0, 1);
    chk_out("cntsat", 0, 0, 1023);
    @(posedge ap_clk); #1;

    // last result left in the registers is the cntsat one (count 1023)
    beat(256, 0); beat(256, 0);
    #2 ap_rst_n = 1'b0;
    #1;
    check("mrst.valid", out_valid, 0);
    check("mrst.ready", in_ready, 0);
    check("mrst.count", out_count, 0);
    check("mrst.data", out_data, 0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    beat(256, 1);
    chk_out("mrst.fresh", 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_acc_requant_21s_14s.md
Name: cnn_acc_requant_21s_14s

Overview:
- Consumer side of the 14s x 7s signed product path: takes the stream of 21-bit signed products from the conv/dense multipliers and accumulates one dot product per vector.
- Requantizes each finished sum back to the 14-bit ap_fixed activation format, with round-half-up and saturation.
- Emits one 14-bit result per vector over a valid/ready handshake.
- Sits between the multiplier array and the activation/pooling stage.

Parameters:
- IN_W, 21, signed product width (din)
- ACC_W, 32, signed accumulator width; must be ≥ IN_W
- OUT_W, 14, signed output width
- SHIFT, 8, arithmetic right shift (fraction bits dropped) during requantization; 0 ≤ SHIFT < ACC_W
- CNT_W, 10, beat-counter width

Ports:
- ap_clk  in  1  clock, all state on rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  IN_W  signed product
- in_last  in  1  marks the final beat of a vector
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  requantized signed result
- out_sat  out  1  out_data was clipped
- out_count  out  CNT_W  number of beats in this vector, including the last beat

Behaviour:
- Reset is asynchronous on ap_rst_n low and clears everything: acc=0, cnt=0, state=IDLE, out_valid=0, out_data=0, out_sat=0, out_count=0.
  - in_ready is 0 while ap_rst_n is low.
  - A reset mid-vector discards the partial sum and any pending output.
- A beat is accepted when in_valid && in_ready.
- A result transfers when out_valid && out_ready.
- in_ready = !out_valid || out_ready, so a pending result stalls all beats. Same-cycle pass-through is allowed: an output is consumed and a new beat accepted in one cycle.
- States:
  - IDLE: acc=0, cnt=0. An accepted non-last beat goes to ACC. An accepted last beat goes to OUT.
  - ACC: each accepted beat does acc += sign_ext(in_data) and cnt += 1. A last beat goes to OUT.
  - OUT: out_valid=1. On handshake, go to IDLE. If a beat is accepted in that same cycle, it is processed exactly as in IDLE.
- Final sum: s = acc + sign_ext(in_data) from the last beat, computed in ACC_W bits.
  - The accumulator wraps modulo 2^ACC_W; overflow is not detected.
- Requantization (SHIFT > 0): r = (s + 2^(SHIFT-1)) >>> SHIFT.
  - The add is done in ACC_W+1 bits, so the rounding add itself cannot wrap.
  - This is round half toward +inf.
- Requantization (SHIFT = 0): r = s.
- Saturation:
  - r > 2^(OUT_W-1)-1 gives out_data = 8191 and out_sat=1.
  - r < -2^(OUT_W-1) gives out_data = -8192 and out_sat=1.
  - Otherwise out_data = r[OUT_W-1:0] and out_sat=0.
- Registering: out_data, out_sat and out_count are registered and load in the same cycle the last beat is accepted.
  - Latency from last-beat acceptance to out_valid is 1 cycle.
  - The outputs stay stable while out_valid && !out_ready.
- acc and cnt clear in the same cycle the last beat is accepted, so the next vector starts from zero.
- Beat counter:
  - cnt saturates at 2^CNT_W-1; accumulation continues.
  - out_count = saturated cnt + 1, itself capped at 2^CNT_W-1.
- A single-beat vector (last on the first beat) is legal: out_count=1.
- in_data and in_last are ignored when in_valid=0.
- Peak throughput is one beat per cycle, including back-to-back vectors.

Test Plan:
- Reset, then 3 beats 256, 512, -128 with last on the third, out_ready=1. Expect 1 cycle later: out_valid=1, out_data=3 (2.5 rounds up), out_sat=0, out_count=3.
- Single beat -384, last=1. Expect out_data=-1 (-1.5 rounds toward +inf), out_count=1.
- Three beats of 1048575 → out_data=8191, out_sat=1. Three beats of -1048576 → out_data=-8192, out_sat=1.
- Backpressure:
  - Hold out_ready=0 after vector A = {256} completes. in_ready stays 0 and out_data/out_sat/out_count stay stable for 5 cycles.
  - Raise out_ready: A (out_data=1) transfers and in_ready=1 in the same cycle.
  - Next vector B = {512, 512} yields out_data=4.
- Back-to-back vectors: in_valid held high, lasts every 2 beats, out_ready=1. Expect one result per 2 cycles, no lost or duplicated beats, each vector's sum independent of the previous one.
- Reset mid-vector: assert ap_rst_n=0 asynchronously after 2 of 4 beats. Expect out_valid, in_ready, out_data and out_count at 0 immediately. After release, a fresh vector {256} gives out_data=1, out_count=1.
